// File: rtl/vga_scan_gen_pkg.sv
// Shared VGA 640x480@60 timing, game-field dimensions and scan types.
// Imported by the scan generator, the display ROMs and game logic, so they all use the same numbers.
package vga_scan_gen_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_CELL_PX  = 10;

   localparam int GAME_COLS = 64;
   localparam int GAME_ROWS = 48;
   localparam int GAME_W    = 6;
   localparam int GRID_W    = 4;
   localparam int CNT_W     = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // True while v lies in the half-open window [lo, lo+len).
   function automatic logic in_window(cnt_t v, int lo, int len);
      return (v >= cnt_t'(lo)) && (v < cnt_t'(lo + len));
   endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-side bundle: coordinates out to the display ROMs, colour back, and the VGA pins.
// master = scan generator, slave = ROM / pin consumer.
interface vga_scan_gen_if;
   import vga_scan_gen_pkg::*;

   logic [GAME_W-1:0] o_game_x;
   logic [GAME_W-1:0] o_game_y;
   logic [GRID_W-1:0] o_grid_x;
   logic [GRID_W-1:0] o_grid_y;
   logic              o_active;
   logic [23:0]       i_rgb;
   logic [7:0]        o_vga_r;
   logic [7:0]        o_vga_g;
   logic [7:0]        o_vga_b;
   logic              o_vga_hs;
   logic              o_vga_vs;
   logic              o_vga_blank_n;
   logic              o_frame_start;

   modport master (
      output o_game_x, o_game_y, o_grid_x, o_grid_y, o_active,
      input  i_rgb,
      output o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs,
      output o_vga_blank_n, o_frame_start
   );

   modport slave (
      input  o_game_x, o_game_y, o_grid_x, o_grid_y, o_active,
      output i_rgb,
      input  o_vga_r, o_vga_g, o_vga_b, o_vga_hs, o_vga_vs,
      input  o_vga_blank_n, o_frame_start
   );

endinterface

// File: rtl/vga_scan_gen_cell_counter.sv
// Paired cell/grid counter: grid counts 0..CELL_PX-1 and carries into game on wrap.
// Clear has priority over enable; results are registered (0-cycle output of state).
module cell_counter
   import vga_scan_gen_pkg::*;
#(
   parameter int CELL_PX = VGA_CELL_PX
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_clr,
   output logic [GAME_W-1:0] o_game,
   output logic [GRID_W-1:0] o_grid
);

   logic [GAME_W-1:0] game_q, game_d;
   logic [GRID_W-1:0] grid_q, grid_d;

   always_comb begin
      game_d = game_q;
      grid_d = grid_q;
      if (i_clr) begin
         game_d = '0;
         grid_d = '0;
      end else if (i_en) begin
         if (grid_q == GRID_W'(CELL_PX - 1)) begin
            grid_d = '0;
            game_d = game_q + GAME_W'(1);
         end else begin
            grid_d = grid_q + GRID_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         game_q <= '0;
         grid_q <= '0;
      end else begin
         game_q <= game_d;
         grid_q <= grid_d;
      end
   end

   assign o_game = game_q;
   assign o_grid = grid_q;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan: stage 0 walks h/v counters and cell coordinates, stage 1 registers ROM colour with syncs.
// Coordinates to pins is 1 cycle; no backpressure, the ROM must answer within the addressing cycle.
module vga_scan_gen
   import vga_scan_gen_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FRONT  = VGA_H_FRONT,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BACK   = VGA_H_BACK,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FRONT  = VGA_V_FRONT,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BACK   = VGA_V_BACK,
   parameter int CELL_PX  = VGA_CELL_PX
) (
   input logic            i_clk,
   input logic            i_rst,
   vga_scan_gen_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   cnt_t h_cnt_q, h_cnt_d;
   cnt_t v_cnt_q, v_cnt_d;
   logic h_wrap, v_last, v_wrap;
   logic h_vis, v_vis, active;

   logic [GAME_W-1:0] game_x, game_y;
   logic [GRID_W-1:0] grid_x, grid_y;

   rgb_t rgb_q, rgb_d;
   logic blank_n_q, blank_n_d;
   logic hs_q, hs_d;
   logic vs_q, vs_d;
   logic frame_start_q, frame_start_d;

   assign h_wrap = (h_cnt_q == cnt_t'(H_TOTAL - 1));
   assign v_last = (v_cnt_q == cnt_t'(V_TOTAL - 1));
   assign v_wrap = h_wrap && v_last;
   assign h_vis  = (h_cnt_q < cnt_t'(H_ACTIVE));
   assign v_vis  = (v_cnt_q < cnt_t'(V_ACTIVE));
   assign active = h_vis && v_vis;

   always_comb begin
      h_cnt_d = h_cnt_q + cnt_t'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         h_cnt_d = '0;
         v_cnt_d = v_last ? '0 : v_cnt_q + cnt_t'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Coordinates are tracked incrementally alongside the raw counters, never derived by division.
   cell_counter #(.CELL_PX(CELL_PX)) u_cell_x (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (h_vis),
      .i_clr  (h_wrap),
      .o_game (game_x),
      .o_grid (grid_x)
   );

   cell_counter #(.CELL_PX(CELL_PX)) u_cell_y (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (h_wrap && v_vis),
      .i_clr  (v_wrap),
      .o_game (game_y),
      .o_grid (grid_y)
   );

   assign bus.o_active = active;
   assign bus.o_game_x = active ? game_x : '0;
   assign bus.o_game_y = active ? game_y : '0;
   assign bus.o_grid_x = active ? grid_x : '0;
   assign bus.o_grid_y = active ? grid_y : '0;

   // Sync, blank and strobe come from the same scan position as the colour, so they stay aligned.
   always_comb begin
      rgb_d         = active ? rgb_t'(bus.i_rgb) : '0;
      blank_n_d     = active;
      hs_d          = !in_window(h_cnt_q, H_ACTIVE + H_FRONT, H_SYNC);
      vs_d          = !in_window(v_cnt_q, V_ACTIVE + V_FRONT, V_SYNC);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == cnt_t'(V_ACTIVE));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rgb_q         <= '0;
         blank_n_q     <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         rgb_q         <= rgb_d;
         blank_n_q     <= blank_n_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.o_vga_r       = rgb_q.r;
   assign bus.o_vga_g       = rgb_q.g;
   assign bus.o_vga_b       = rgb_q.b;
   assign bus.o_vga_blank_n = blank_n_q;
   assign bus.o_vga_hs      = hs_q;
   assign bus.o_vga_vs      = vs_q;
   assign bus.o_frame_start = frame_start_q;

endmodule
